// File: rtl/adc_packer_if.sv
// adc_packer_if: packed-word valid/ready bus from adc_packer to the
// capture-buffer writer. The packer drives data, valid and address; the
// writer returns ready.
interface adc_packer_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 14
);
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              i_ready;
    logic [ADDR_W-1:0] o_addr;

    modport master (
        output o_data,
        output o_valid,
        output o_addr,
        input  i_ready
    );

    modport slave (
        input  o_data,
        input  o_valid,
        input  o_addr,
        output i_ready
    );
endinterface

// File: rtl/adc_packer.sv
// adc_packer: packs LANES samples of SAMPLE_W bits, zero-extended into
// LANE_W-bit lanes (lane 0 in the low bits), and presents each word with a
// wrapping write address on a valid/ready bus. Words that complete while the
// output register is still occupied are dropped and flagged in o_overflow.
// Build option: define ADC_PACKER_TESTPAT_EN to include the ramp test-pattern
// generator selected by i_mode; without it i_mode is ignored (live only).
module adc_packer #(
    parameter int unsigned SAMPLE_W = 14,
    parameter int unsigned LANE_W   = 16,
    parameter int unsigned LANES    = 4,
    parameter int unsigned ADDR_W   = 14
) (
    input  logic                i_62clk,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_mode,
    input  logic [SAMPLE_W-1:0] i_sample,
    input  logic                i_sample_valid,
    adc_packer_if.master        bus,
    output logic                o_wrap,
    output logic                o_overflow
);
    localparam int unsigned WORD_W = LANES * LANE_W;
    localparam int unsigned IDX_W  = $clog2(LANES);

    typedef enum logic {
        S_IDLE,
        S_FILL
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     lane_idx;
    logic [WORD_W-1:0]    pack;
    logic [WORD_W-1:0]    word_next;
    logic [SAMPLE_W-1:0]  sample;
    logic [LANE_W-1:0]    lane_val;
    logic                 slot;
    logic                 last_lane;
    logic                 word_done;
    logic                 handshake;
    logic                 load;

`ifdef ADC_PACKER_TESTPAT_EN
    logic [SAMPLE_W-1:0]  ramp;

    assign slot   = (state == S_FILL) && i_enable && (i_mode || i_sample_valid);
    assign sample = i_mode ? ramp : i_sample;

    // Ramp advances once per slot, whichever source fed that slot.
    always_ff @(posedge i_62clk or posedge i_reset) begin
        if (i_reset) begin
            ramp <= '0;
        end else if (slot) begin
            ramp <= ramp + SAMPLE_W'(1);
        end
    end
`else
    logic unused_mode;

    assign unused_mode = i_mode;
    assign slot        = (state == S_FILL) && i_enable && i_sample_valid;
    assign sample      = i_sample;
`endif

    assign lane_val  = LANE_W'(sample);
    assign last_lane = (lane_idx == IDX_W'(LANES - 1));
    assign word_done = slot && last_lane;
    assign handshake = bus.o_valid && bus.i_ready;
    assign load      = word_done && (!bus.o_valid || handshake);

    // Current partial word with this slot's sample merged into its lane.
    always_comb begin
        word_next = pack;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (lane_idx == IDX_W'(i)) begin
                word_next[i*LANE_W +: LANE_W] = lane_val;
            end
        end
    end

    // Packing FSM: idles (discarding any partial word) until enabled, then
    // fills lanes back to back on every slot.
    always_ff @(posedge i_62clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= S_IDLE;
            lane_idx <= '0;
            pack     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    lane_idx <= '0;
                    pack     <= '0;
                    if (i_enable) begin
                        state <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (!i_enable) begin
                        state    <= S_IDLE;
                        lane_idx <= '0;
                        pack     <= '0;
                    end else if (slot) begin
                        pack     <= word_next;
                        lane_idx <= last_lane ? '0 : lane_idx + IDX_W'(1);
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    lane_idx <= '0;
                    pack     <= '0;
                end
            endcase
        end
    end

    // Output register: loads a finished word when empty or draining this
    // cycle, otherwise drops it; address advances on every handshake.
    always_ff @(posedge i_62clk or posedge i_reset) begin
        if (i_reset) begin
            bus.o_data  <= '0;
            bus.o_valid <= 1'b0;
            bus.o_addr  <= '0;
            o_wrap      <= 1'b0;
            o_overflow  <= 1'b0;
        end else begin
            o_wrap <= 1'b0;
            if (load) begin
                bus.o_data  <= word_next;
                bus.o_valid <= 1'b1;
            end else if (handshake) begin
                bus.o_valid <= 1'b0;
            end
            if (word_done && !load) begin
                o_overflow <= 1'b1;
            end
            if (handshake) begin
                bus.o_addr <= bus.o_addr + ADDR_W'(1);
                o_wrap     <= (bus.o_addr == '1);
            end
        end
    end
endmodule
